// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: shares one write port between the pipeline
// write-back stage and a 2-entry in-order buffer of multiply/divide results.
module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_wen,
    input  logic [4:0]  pipe_waddr,
    input  logic [31:0] pipe_wdata,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_waddr,
    input  logic [31:0] md_wdata,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        pipe_stall,
    output logic [1:0]  fifo_count
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {NORMAL, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [4:0]    q_addr [2];
    logic [31:0]   q_data [2];
    logic          rd_ptr, wr_ptr;
    logic [1:0]    count;
    logic          push, pop, sel_pipe, sel_fifo;
    logic [4:0]    sel_addr;
    logic [31:0]   sel_data;
    logic [CW-1:0] starve_cnt;
    logic          waiting, starve_hit;

    assign md_ready   = (count < 2'd2) && !rst;
    assign push       = md_valid && md_ready;
    assign fifo_count = count;

    // The pipeline wins the port unless a drain cycle is forcing the head out.
    assign sel_pipe = !rst && !pipe_stall && pipe_wen;
    assign sel_fifo = !rst && !sel_pipe && (count != 2'd0);
    assign pop      = sel_fifo;

    always_comb begin
        sel_addr = 5'd0;
        sel_data = 32'd0;
        if (sel_pipe) begin
            sel_addr = pipe_waddr;
            sel_data = pipe_wdata;
        end else if (sel_fifo) begin
            sel_addr = q_addr[rd_ptr];
            sel_data = q_data[rd_ptr];
        end
    end

    assign rf_wen   = (sel_pipe || sel_fifo) && (sel_addr != 5'd0);
    assign rf_waddr = sel_addr;
    assign rf_wdata = sel_data;

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= md_waddr;
            q_data[wr_ptr] <= md_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // A buffered result that loses the port again is about to hit the limit.
    assign waiting    = (count != 2'd0) && !pop;
    assign starve_hit = waiting && ((int'(starve_cnt) + 1) >= (STARVE_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst || !waiting) starve_cnt <= '0;
        else                 starve_cnt <= starve_cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= NORMAL;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            NORMAL:  if (starve_hit) state_nxt = DRAIN;
            DRAIN:   state_nxt = NORMAL;
            default: state_nxt = NORMAL;
        endcase
    end

    always_comb begin
        pipe_stall = (state == DRAIN);
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_wb_port_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_wen = 1'b0;
    logic [4:0]  pipe_waddr = '0;
    logic [31:0] pipe_wdata = '0;
    logic        md_valid = 1'b0;
    logic        md_ready;
    logic [4:0]  md_waddr = '0;
    logic [31:0] md_wdata = '0;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        pipe_stall;
    logic [1:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    wb_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .pipe_wen(pipe_wen), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
        .md_valid(md_valid), .md_ready(md_ready), .md_waddr(md_waddr), .md_wdata(md_wdata),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pipe_stall(pipe_stall), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pending results as a queue, stall as a one-shot flag.
    logic [36:0] mq[$];
    bit          m_stall = 1'b0;
    int          m_wait = 0;

    always @(negedge clk) begin
        bit          sel, pop_e, ew, er, waiting;
        logic [4:0]  ea;
        logic [31:0] ed;
        int          sz;
        sz = mq.size();
        sel = 1'b0; pop_e = 1'b0; ea = '0; ed = '0;
        er = !rst && (sz < 2);
        if (!rst) begin
            if (!m_stall && pipe_wen) begin
                sel = 1'b1; ea = pipe_waddr; ed = pipe_wdata;
            end else if (sz > 0) begin
                sel = 1'b1; pop_e = 1'b1; ea = mq[0][36:32]; ed = mq[0][31:0];
            end
        end
        ew = sel && (ea != 5'd0);
        chk("m_rf_wen", rf_wen, ew);
        if (ew || !sel) begin
            chk("m_rf_waddr", rf_waddr, ea);
            chk("m_rf_wdata", rf_wdata, ed);
        end
        chk("m_md_ready", md_ready, er);
        chk("m_pipe_stall", pipe_stall, m_stall);
        chk("m_fifo_count", fifo_count, sz);

        if (rst) begin
            mq.delete();
            m_stall = 1'b0;
            m_wait = 0;
        end else begin
            waiting = (sz > 0) && !pop_e;
            if (pop_e) void'(mq.pop_front());
            if (md_valid && er) mq.push_back({md_waddr, md_wdata});
            if (m_stall) begin
                m_stall = 1'b0;
                m_wait = 0;
            end else if (waiting) begin
                m_wait++;
                if (m_wait >= STARVE_LIMIT - 1) m_stall = 1'b1;
            end else begin
                m_wait = 0;
            end
        end
    end

    task automatic tick(input bit r, input bit pw, input logic [4:0] pa, input logic [31:0] pd,
                        input bit mv, input logic [4:0] ma, input logic [31:0] mdd);
        @(posedge clk);
        #1;
        rst = r; pipe_wen = pw; pipe_waddr = pa; pipe_wdata = pd;
        md_valid = mv; md_waddr = ma; md_wdata = mdd;
        #3;
    endtask

    task automatic idle();
        tick(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    task automatic pipe_only();
        tick(0, 1, 5'd3, 32'hAAAA, 0, 5'd0, 32'd0);
    endtask

    initial begin
        // reset
        tick(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        tick(1, 0, 5'd0, 32'd0, 1, 5'd4, 32'h44);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_pipe_stall", pipe_stall, 0);
        chk("rst_md_ready", md_ready, 0);
        chk("rst_rf_wen", rf_wen, 0);
        idle();
        chk("post_rst_md_ready", md_ready, 1);

        // idle port: one-cycle latency, no bypass
        tick(0, 0, 5'd0, 32'd0, 1, 5'd5, 32'h1234);
        chk("idle_no_bypass", rf_wen, 0);
        idle();
        chk("idle_rf_wen", rf_wen, 1);
        chk("idle_rf_waddr", rf_waddr, 5);
        chk("idle_rf_wdata", rf_wdata, 32'h1234);
        idle();
        chk("idle_drained", fifo_count, 0);

        // register 0 suppressed but still popped
        tick(0, 0, 5'd0, 32'd0, 1, 5'd0, 32'hFFFF);
        idle();
        chk("r0_count1", fifo_count, 1);
        chk("r0_wen", rf_wen, 0);
        idle();
        chk("r0_count0", fifo_count, 0);

        // simultaneous push and pop
        tick(0, 0, 5'd0, 32'd0, 1, 5'd9, 32'h99);
        tick(0, 0, 5'd0, 32'd0, 1, 5'd10, 32'hAA);
        chk("sim_wen", rf_wen, 1);
        chk("sim_waddr_head", rf_waddr, 9);
        chk("sim_count", fifo_count, 1);
        idle();
        chk("sim_waddr_next", rf_waddr, 10);
        chk("sim_wdata_next", rf_wdata, 32'hAA);
        chk("sim_count_hold", fifo_count, 1);
        idle();
        chk("sim_empty", fifo_count, 0);

        // priority and starvation drain
        tick(0, 1, 5'd3, 32'hAAAA, 1, 5'd7, 32'h77);
        chk("pri_c0_waddr", rf_waddr, 3);
        tick(0, 1, 5'd3, 32'hAAAA, 1, 5'd8, 32'h88);
        chk("pri_c1_count", fifo_count, 1);
        tick(0, 1, 5'd3, 32'hAAAA, 1, 5'd20, 32'h20);
        chk("pri_c2_count", fifo_count, 2);
        chk("pri_c2_ready", md_ready, 0);
        chk("pri_c2_waddr", rf_waddr, 3);
        pipe_only();
        chk("st_c3_stall", pipe_stall, 0);
        pipe_only();
        chk("st_c4_stall", pipe_stall, 1);
        chk("st_c4_waddr", rf_waddr, 7);
        chk("st_c4_wdata", rf_wdata, 32'h77);
        pipe_only();
        chk("st_c5_stall", pipe_stall, 0);
        chk("st_c5_count", fifo_count, 1);
        chk("st_c5_waddr", rf_waddr, 3);
        pipe_only();
        pipe_only();
        chk("st_c7_stall", pipe_stall, 0);
        pipe_only();
        chk("st_c8_stall", pipe_stall, 1);
        chk("st_c8_waddr", rf_waddr, 8);
        pipe_only();
        chk("st_c9_count", fifo_count, 0);
        chk("st_c9_stall", pipe_stall, 0);

        // reset mid-drain
        tick(0, 1, 5'd3, 32'hAAAA, 1, 5'd11, 32'hB1);
        tick(0, 1, 5'd3, 32'hAAAA, 1, 5'd12, 32'hB2);
        pipe_only();
        pipe_only();
        tick(1, 1, 5'd3, 32'hAAAA, 1, 5'd13, 32'hB3);
        chk("rd_stall_during", pipe_stall, 1);
        chk("rd_count_during", fifo_count, 2);
        chk("rd_wen_during", rf_wen, 0);
        chk("rd_ready_during", md_ready, 0);
        idle();
        chk("rd_count_after", fifo_count, 0);
        chk("rd_stall_after", pipe_stall, 0);
        chk("rd_wen_after", rf_wen, 0);
        chk("rd_ready_after", md_ready, 1);

        // mixed traffic table, checked by the model
        for (int i = 0; i < 40; i++)
            tick(0, (i % 4) != 0, 5'(i), 32'(i * 257), (i % 3) != 1, 5'(i * 7), 32'(32'h1000 + i));
        for (int i = 0; i < 6; i++) idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
